// File: rtl/register_bank.sv
// Eight-entry working register file for the CPU core: one synchronous write port
// and one combinational read port that drives the shared internal data bus.
module register_bank #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_REGS   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  reg_wr_en,
    input  logic                  reg_rd_en,
    input  logic [2:0]            reg_in_sel,
    input  logic [2:0]            reg_out_sel,
    input  logic [DATA_WIDTH-1:0] reg_wr_byte,
    output logic [DATA_WIDTH-1:0] reg_rd_byte
);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [DATA_WIDTH-1:0] rd_data_c;

    // Next-state: only the selected entry takes the write data.
    always_comb begin
        regs_d = regs_q;
        if (reg_wr_en) begin
            regs_d[reg_in_sel] = reg_wr_byte;
        end
    end

    // Reset wins over any write presented in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read path has no write bypass: it always shows the stored value.
    assign rd_data_c = regs_q[reg_out_sel];

    // Bus is released whenever read enable is low, independent of reset.
    assign reg_rd_byte = reg_rd_en ? rd_data_c : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus a randomized
// phase compared against a simple array model of the register file.
module tb_register_bank;

    logic       clock;
    logic       reset;
    logic       reg_wr_en;
    logic       reg_rd_en;
    logic [2:0] reg_in_sel;
    logic [2:0] reg_out_sel;
    logic [7:0] reg_wr_byte;
    wire  [7:0] reg_rd_byte;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] ref_regs [8];

    register_bank #(.DATA_WIDTH(8), .NUM_REGS(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_in_sel  (reg_in_sel),
        .reg_out_sel (reg_out_sel),
        .reg_wr_byte (reg_wr_byte),
        .reg_rd_byte (reg_rd_byte)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] expected_read(input logic en, input logic [2:0] sel);
        logic [7:0] zz;
        zz = 8'hzz;
        return en ? ref_regs[sel] : zz;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) ref_regs[i] = 8'h00;
    endtask

    // Sweep every read index on successive low phases; write inputs are left as-is.
    task automatic read_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            reg_rd_en   = 1'b1;
            reg_out_sel = 3'(i);
            #1;
            check_val($sformatf("%s_r%0d", tag, i), reg_rd_byte, ref_regs[i]);
        end
    endtask

    initial begin
        reset       = 1'b0;
        reg_wr_en   = 1'b0;
        reg_rd_en   = 1'b1;
        reg_in_sel  = 3'd0;
        reg_out_sel = 3'd0;
        reg_wr_byte = 8'h00;
        #2 reset = 1'b1;
        clear_model();

        // Reads while reset is held return zero for every index.
        read_all("reset");
        @(negedge clock);
        reset = 1'b0;

        // Write 0x10+i to Ri on consecutive edges, verifying the whole bank each time.
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            reg_wr_en   = 1'b1;
            reg_in_sel  = 3'(i);
            reg_wr_byte = 8'h10 + 8'(i);
            @(posedge clock);
            ref_regs[i] = 8'h10 + 8'(i);
            @(negedge clock);
            reg_wr_en = 1'b0;
            read_all($sformatf("wr%0d", i));
        end

        // Output release and same-cycle read.
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            reg_rd_en   = 1'b0;
            reg_out_sel = 3'($urandom_range(0, 7));
            #1;
            check_val("rd_dis_z", reg_rd_byte, expected_read(1'b0, reg_out_sel));
        end
        reg_rd_en   = 1'b1;
        reg_out_sel = 3'd3;
        #1;
        check_val("rd_en_r3", reg_rd_byte, 8'h13);

        // Same-register read during write: old value before the edge, new after.
        @(negedge clock);
        reg_in_sel  = 3'd5;
        reg_out_sel = 3'd5;
        reg_wr_byte = 8'hA5;
        reg_wr_en   = 1'b1;
        #1;
        check_val("rdw_before", reg_rd_byte, 8'h15);
        @(posedge clock);
        ref_regs[5] = 8'hA5;
        #1;
        check_val("rdw_after", reg_rd_byte, 8'hA5);

        // Write enable low: data input ignored over several edges.
        @(negedge clock);
        reg_wr_en   = 1'b0;
        reg_wr_byte = 8'hFF;
        repeat (4) @(posedge clock);
        read_all("hold");

        // Asynchronous reset pulse between edges with a write held pending.
        @(negedge clock);
        reg_in_sel  = 3'd2;
        reg_wr_byte = 8'h77;
        reg_wr_en   = 1'b1;
        reg_out_sel = 3'd5;
        #1;
        reset = 1'b1;
        clear_model();
        #1;
        check_val("async_rst_r5", reg_rd_byte, 8'h00);
        read_all("in_rst");
        @(negedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        ref_regs[2] = 8'h77;
        #1;
        reg_wr_en = 1'b0;
        read_all("post_rst");

        // Randomized traffic with occasional mid-cycle reset pulses.
        for (int c = 0; c < 400; c++) begin
            logic do_rst;
            @(negedge clock);
            reg_wr_en   = 1'($urandom_range(0, 1));
            reg_rd_en   = ($urandom_range(0, 7) != 0);
            reg_in_sel  = 3'($urandom_range(0, 7));
            reg_out_sel = 3'($urandom_range(0, 7));
            reg_wr_byte = 8'($urandom);
            do_rst      = ($urandom_range(0, 31) == 0);
            #1;
            check_val("rand_rd", reg_rd_byte, expected_read(reg_rd_en, reg_out_sel));
            if (do_rst) begin
                reset = 1'b1;
                clear_model();
                #1;
                check_val("rand_rst_rd", reg_rd_byte, expected_read(reg_rd_en, reg_out_sel));
                @(posedge clock);
                #1 reset = 1'b0;
            end else begin
                @(posedge clock);
                if (reg_wr_en) ref_regs[reg_in_sel] = reg_wr_byte;
                #1;
                check_val("rand_post", reg_rd_byte, expected_read(reg_rd_en, reg_out_sel));
            end
        end

        @(negedge clock);
        reg_wr_en = 1'b0;
        read_all("final");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of each working register and both data ports.
REQ-002 Parameter NUM_REGS, default 8, number of working registers R0..R7; selects are 3 bits wide, so only 8 is supported.
REQ-003 clock  input  1  single clock; all register updates occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset; clears all registers immediately, independent of clock.
REQ-005 reg_wr_en  input  1  write enable; when high at a rising clock edge, the register addressed by reg_in_sel is written.
REQ-006 reg_rd_en  input  1  read enable; when high, the bank drives reg_rd_byte; when low, the output is released.
REQ-007 reg_in_sel  input  3  write register index (0 = R0 .. 7 = R7).
REQ-008 reg_out_sel  input  3  read register index (0 = R0 .. 7 = R7).
REQ-009 reg_wr_byte  input  8  write data.
REQ-010 reg_rd_byte  output  8  tri-state read data, shared with other drivers of the CPU internal data bus.

Function
REQ-011 The bank SHALL hold 8 independent 8-bit registers R0..R7.
REQ-012 Write: on a rising clock edge with reset low and reg_wr_en high, R[reg_in_sel] SHALL take reg_wr_byte; all other registers SHALL hold their values.
REQ-013 With reg_wr_en low, no register SHALL change on a clock edge.
REQ-014 Read is combinational: while reg_rd_en is high, reg_rd_byte SHALL equal R[reg_out_sel] within the same cycle, with no clock latency.
REQ-015 While reg_rd_en is low, reg_rd_byte SHALL be high-impedance (8'hzz) on all 8 bits.
REQ-016 Read and write SHALL operate independently in the same cycle; any combination of reg_in_sel and reg_out_sel is legal.
REQ-017 Same-register read during write: before the edge, reg_rd_byte SHALL show the old value; after the edge, it SHALL show the new value. There is no write-through bypass.
REQ-018 reg_rd_en SHALL have no effect on register contents; reg_wr_en SHALL have no effect on the output drive state.
REQ-019 Selects SHALL be fully decoded; no index is reserved, and there is no wrap or out-of-range case.
REQ-020 The bank SHALL implement no bank switching (no PSW RS bits); R0..R7 form a single fixed bank.

Reset
REQ-021 While reset is high, all R0..R7 SHALL be 8'h00, asynchronously, regardless of clock.
REQ-022 Reset SHALL take priority over a simultaneous write; a write presented during reset SHALL be discarded.
REQ-023 After reset deasserts, the first rising edge with reg_wr_en high SHALL perform a normal write.
REQ-024 The reg_rd_byte drive state SHALL depend only on reg_rd_en, also during reset: reading during reset SHALL return 8'h00.
REQ-025 Reset asserted mid-sequence SHALL clear all registers, including any written in the preceding cycle.

Verification
REQ-026 Assert reset, then read R0..R7 with reg_rd_en=1 -> reg_rd_byte = 8'h00 for every index.
REQ-027 Write R(i) = 8'h10+i for i = 0..7 on consecutive edges, then read each -> 8'h10..8'h17; the other registers are unchanged after each write.
REQ-028 Set reg_rd_en=0 with any select -> reg_rd_byte = 8'hzz; set reg_rd_en=1, reg_out_sel=3 -> 8'h13 in the same cycle.
REQ-029 Set reg_in_sel=reg_out_sel=5, reg_wr_byte=8'hA5, reg_wr_en=1 -> 8'h15 before the edge, 8'hA5 after it.
REQ-030 Hold reg_wr_en=0 with reg_wr_byte=8'hFF for 4 edges -> all registers unchanged.
REQ-031 Pulse reset asynchronously between edges after the writes, with reg_wr_en=1 and reg_wr_byte=8'h77 held high -> all registers read 8'h00 immediately; after reset releases, the next edge writes 8'h77 to R[reg_in_sel] only.
